burst_tracker: RTL
==================

// Module: burst_tracker
// PURPOSE
// - Parametrised successor of the fixed 16-beat AXI4-Lite burst counter.
// - Counts beats of one transfer against a runtime limit, in one-shot or wrap (auto-reload) mode.
// - Reports progress, last beat, completion, overrun and (optionally) stall timeout.
// - Sits beside the AXI4-Lite master/slave FSMs; i_run = one accepted beat (VALID & READY).
// PARAMETERS
// - CNT_W           8    width of beat count and limit; burst length = limit+1, max 2**CNT_W beats
// - TIMEOUT_CYCLES  256  stall cycles in COUNT with no beat before o_timeout (only with macro)
// PORTS
// - i_clk       in   1      clock, rising edge
// - i_arst      in   1      reset, asynchronous, active-high
// - i_restartn  in   1      synchronous clear, active-low
// - i_start     in   1      arm a new burst; samples i_limit, i_wrap
// - i_limit     in   CNT_W  beat index of last beat (beats = i_limit+1)
// - i_wrap      in   1      0 = one-shot, 1 = wrap/auto-reload
// - i_run       in   1      one beat transferred this cycle
// - o_count     out  CNT_W  beats counted in current burst (0..limit)
// - o_busy      out  1      state == COUNT
// - o_last      out  1      state == COUNT and o_count == latched limit (next beat is last)
// - o_done      out  1      1-cycle pulse, cycle after the last beat
// - o_overrun   out  1      sticky: beat seen while not in COUNT
// - o_timeout   out  1      sticky stall flag (0 when macro absent)
// BEHAVIOUR
// - Reset (i_arst): state IDLE, count 0, limit_q 0, wrap_q 0; all outputs 0.
// - FSM states: IDLE, COUNT, HOLD. Sync priority each edge: ~i_restartn > i_start > i_run.
// - ~i_restartn: state IDLE; count, o_done, o_overrun, o_timeout, stall counter cleared.
// - i_start (any state): limit_q<=i_limit, wrap_q<=i_wrap, count<=0, state COUNT.
//   A simultaneous i_run is dropped: not counted, no overrun.
// - COUNT, i_run, count != limit_q: count+1.
// - COUNT, i_run, count == limit_q: o_done=1 next cycle.
//   - One-shot: state HOLD, count holds at limit_q.
//   - Wrap: count<=0, stay COUNT.
// - limit_q == 0: every beat completes a burst.
//   - Wrap: o_done high on consecutive cycles under back-to-back beats.
// - HOLD/IDLE, i_run: o_overrun<=1 (sticky); count unchanged.
// - HOLD exits only via i_start or ~i_restartn.
// - Count never exceeds limit_q; no arithmetic wrap beyond CNT_W.
// - o_count, o_busy, o_last are decoded from flops only (no input-to-output comb path).
// - Latency: beat -> o_count update 1 cycle; last beat -> o_done 1 cycle.
// CONFIGURATION
// - BURST_TRACKER_TIMEOUT_EN defined: stall counter $clog2(TIMEOUT_CYCLES+1) bits.
//   - Counts cycles in COUNT with i_run=0; zeroed on any beat, i_start, restart, leaving COUNT.
//   - Reaching TIMEOUT_CYCLES-1 with no beat: o_timeout<=1 next edge (sticky).
//   - Stall counter saturates; FSM is unaffected.
// - Macro undefined: no stall counter; o_timeout tied 1'b0. Port list identical.
// STRUCTURE
// - burst_pkg: typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_HOLD} burst_state_t;
//   localparam TIMEOUT_DEF = 256.
// - Sub-module stall_timer (compiled only with BURST_TRACKER_TIMEOUT_EN):
//   inputs clear/tick, output expired. FSM + counter in burst_tracker.
// TESTING
// - Reset: assert i_arst mid-burst (count 5) -> all outputs 0 same cycle, state IDLE.
// - One-shot: start limit=15, 16 beats incl. gaps -> o_last at count 15, o_done 1 cycle
//   after 16th beat, count holds 15, o_busy 0; 17th beat -> o_overrun=1.
// - Wrap: start limit=3, wrap=1, 12 back-to-back beats -> o_done pulses 3 times,
//   count sequence 0,1,2,3,0..., o_busy stays 1.
// - Edges: limit=0, wrap=1, continuous beats -> o_done high every cycle;
//   i_start with i_run same cycle -> count 0 next cycle;
//   i_restartn low with i_start -> IDLE wins, o_overrun cleared.
// - Max width: CNT_W=4, limit=15 -> 16 beats, no count overflow past 15.
// - Timeout (macro on, TIMEOUT_CYCLES=8): start, 8 idle cycles -> o_timeout=1;
//   one beat does not clear it; i_start clears it. Macro off -> o_timeout stays 0.

Source files
------------

// File: rtl/burst_pkg.sv
// Shared types and defaults for the burst tracker and its stall timer.
package burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } burst_state_t;

  localparam int TIMEOUT_DEF = 256;

endpackage

// File: rtl/stall_timer.sv
// Saturating stall-cycle counter; expired once TIMEOUT_CYCLES-1 idle ticks have been seen.
// Only present when BURST_TRACKER_TIMEOUT_EN is defined.
`ifdef BURST_TRACKER_TIMEOUT_EN
module stall_timer #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic arst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int            CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] TOP  = CW'(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && (cnt != TOP)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt >= LAST);

endmodule
`endif

// File: rtl/burst_tracker.sv
// Beat counter for one AXI4-Lite transfer against a runtime limit, one-shot or wrap mode.
// Stall timeout is built only when BURST_TRACKER_TIMEOUT_EN is defined.
//
// state    | meaning
// ST_IDLE  | no burst armed; beats are overruns
// ST_COUNT | counting beats toward limit_q
// ST_HOLD  | one-shot burst finished; count held at limit_q
module burst_tracker
  import burst_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_restartn,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_limit,
  input  logic             i_wrap,
  input  logic             i_run,
  output logic [CNT_W-1:0] o_count,
  output logic             o_busy,
  output logic             o_last,
  output logic             o_done,
  output logic             o_overrun,
  output logic             o_timeout
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("burst_tracker: TIMEOUT_CYCLES must be at least 2");
  end

  burst_state_t     state, state_nxt;
  logic [CNT_W-1:0] count_q, limit_q;
  logic             wrap_q, done_q, overrun_q;
  logic             at_limit, beat;

  assign at_limit = (count_q == limit_q);
  assign beat     = (state == ST_COUNT) && i_run;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!i_restartn) begin
      state_nxt = ST_IDLE;
    end else if (i_start) begin
      state_nxt = ST_COUNT;
    end else if (beat && at_limit && !wrap_q) begin
      state_nxt = ST_HOLD;
    end
  end

  // A beat coinciding with i_start belongs to no burst and is dropped silently.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      count_q   <= '0;
      limit_q   <= '0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (!i_restartn) begin
      count_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (i_start) begin
      count_q <= '0;
      limit_q <= i_limit;
      wrap_q  <= i_wrap;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (beat) begin
        if (at_limit) begin
          done_q <= 1'b1;
          if (wrap_q) count_q <= '0;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end else if (i_run) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign o_count   = count_q;
  assign o_busy    = (state == ST_COUNT);
  assign o_last    = (state == ST_COUNT) && at_limit;
  assign o_done    = done_q;
  assign o_overrun = overrun_q;

`ifdef BURST_TRACKER_TIMEOUT_EN
  logic stall_clear, stall_tick, stall_expired, timeout_q;

  assign stall_tick  = (state == ST_COUNT) && !i_run;
  assign stall_clear = !i_restartn || i_start || (state != ST_COUNT) || i_run;

  stall_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_stall_timer (
    .clk     (i_clk),
    .arst    (i_arst),
    .clear   (stall_clear),
    .tick    (stall_tick),
    .expired (stall_expired)
  );

  // Sticky across beats; only a new burst or a restart drops it.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      timeout_q <= 1'b0;
    end else if (!i_restartn || i_start) begin
      timeout_q <= 1'b0;
    end else if (stall_tick && stall_expired) begin
      timeout_q <= 1'b1;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule
